acc_responder: RTL
==================

ACC_RESPONDER -- requirements
Module: acc_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of entries in the request queue and in the tag queue.
REQ-002 SHALL have parameter XLEN, default 64, which sets the operand and result width.
REQ-003 SHALL have parameter TRANS_ID_BITS, default 3, which sets the transaction-ID width.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port acc_req_valid_i, input, 1: a request from the CPU dispatcher is valid.
REQ-007 SHALL have port acc_req_ready_o, output, 1: the responder accepts the request.
REQ-008 SHALL have port acc_insn_i, input, 32: instruction word.
REQ-009 SHALL have ports acc_rs1_i and acc_rs2_i, input, XLEN each: source operands.
REQ-010 SHALL have port acc_trans_id_i, input, TRANS_ID_BITS: scoreboard transaction ID.
REQ-011 SHALL have port be_valid_o, output, 1, and be_ready_i, input, 1: issue handshake to the back-end.
REQ-012 SHALL have ports be_insn_o (32), be_rs1_o (XLEN) and be_rs2_o (XLEN), output: the issued instruction and its operands.
REQ-013 SHALL have port be_done_i, input, 1, and be_done_ready_o, output, 1: in-order completion handshake from the back-end.
REQ-014 SHALL have port be_result_i, input, XLEN: completion result.
REQ-015 SHALL have port acc_resp_valid_o, output, 1, and acc_resp_ready_i, input, 1: response handshake to the CPU.
REQ-016 SHALL have ports acc_resp_trans_id_o (TRANS_ID_BITS) and acc_resp_result_o (XLEN), output: the response payload.
REQ-017 SHALL have ports acc_load_complete_o and acc_store_complete_o, output, 1 each: single-cycle completion pulses.
REQ-018 SHALL have port acc_store_pending_o, output, 1: at least one accepted store has not completed.
REQ-019 SHALL have port protocol_err_o, output, 1: sticky protocol-violation flag.

Function
REQ-020 SHALL classify an instruction as a load when insn[6:0]==7'b0000111, as a store when insn[6:0]==7'b0100111, and as other for any other value.
REQ-021 SHALL buffer requests in a registered, non-fall-through request FIFO of DEPTH entries; each entry holds {insn, rs1, rs2, trans_id, is_ld, is_st}.
REQ-022 SHALL drive acc_req_ready_o = !req_fifo_full && (inflight < DEPTH), where inflight counts requests that are accepted but not yet responded (width clog2(DEPTH+1)).
REQ-023 SHALL drive be_valid_o, at the earliest, one cycle after the request is accepted (minimum 1-cycle latency) and whenever the request FIFO is non-empty.
REQ-024 SHALL hold be_insn_o, be_rs1_o and be_rs2_o stable while be_valid_o is high and be_ready_i is low.
REQ-025 SHALL, on a back-end issue handshake (be_valid_o && be_ready_i), pop the request FIFO and push {trans_id, is_ld, is_st} into an in-order tag FIFO of DEPTH entries.
REQ-026 SHALL drive be_done_ready_o = !tag_empty && (!acc_resp_valid_o || acc_resp_ready_i), so the response register can refill in the same cycle it drains.
REQ-027 SHALL, on a done handshake, pop the tag FIFO and load the response register with {tag.trans_id, be_result_i, is_ld, is_st}; acc_resp_valid_o rises in the next cycle.
REQ-028 SHALL hold acc_resp_valid_o and the response payload stable until acc_resp_ready_i is high.
REQ-029 SHALL clear acc_resp_valid_o on a response handshake unless a new done handshake occurs in the same cycle.
REQ-030 SHALL pulse acc_load_complete_o or acc_store_complete_o for exactly one cycle, combinationally with the response handshake, for a load or store entry respectively.
REQ-031 SHALL increment a store counter on acceptance of a store request and decrement it on acc_store_complete_o; simultaneous increment and decrement leave it unchanged.
REQ-032 SHALL drive acc_store_pending_o = (store counter != 0).
REQ-033 SHALL increment inflight on request acceptance and decrement it on a response handshake; simultaneous increment and decrement leave it unchanged.
REQ-034 SHALL ignore be_done_i while the tag FIFO is empty and set protocol_err_o, which stays set until reset.
REQ-035 SHALL support back-to-back throughput of 1 request per cycle when the back-end and the CPU are always ready.

Reset
REQ-036 SHALL, on rst_ni low, asynchronously empty both FIFOs and zero inflight and the store counter.
REQ-037 SHALL drive all outputs to 0 during reset, including acc_req_ready_o; acc_req_ready_o rises in the first cycle after reset release.
REQ-038 SHALL discard all in-flight transactions on a reset asserted mid-operation, with no completion pulses emitted.

Verification
REQ-039 Single load, insn=0x02007007, id=5, all ready, result=0xAB -> be_valid_o at cycle +1, acc_resp_valid_o with id=5 and result=0xAB, one acc_load_complete_o pulse.
REQ-040 Four requests with be_ready_i=0 -> acc_req_ready_o=0 after the 4th acceptance; a 5th request stalls until the first response handshake.
REQ-041 Store followed by acc_resp_ready_i held 0 for 3 cycles -> payload stable, acc_store_pending_o=1 until the store-complete pulse, then 0.
REQ-042 Streaming ids 0..7 wrapping to 0 with all ready -> responses in order 0..7,0 at 1 per cycle with no bubbles.
REQ-043 be_done_i asserted with no outstanding issue -> no response produced, protocol_err_o=1 and it persists.
REQ-044 rst_ni pulsed low with 3 transactions in flight -> all outputs 0 immediately, no pulses emitted, clean operation after reset.

Source files
------------

// File: rtl/acc_responder.sv
// Accelerator request/response bridge: queues CPU requests, issues them in order to a back-end,
// and returns in-order results with load/store completion tracking.
module acc_responder #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     acc_req_valid_i,
  output logic                     acc_req_ready_o,
  input  logic [31:0]              acc_insn_i,
  input  logic [XLEN-1:0]          acc_rs1_i,
  input  logic [XLEN-1:0]          acc_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] acc_trans_id_i,
  output logic                     be_valid_o,
  input  logic                     be_ready_i,
  output logic [31:0]              be_insn_o,
  output logic [XLEN-1:0]          be_rs1_o,
  output logic [XLEN-1:0]          be_rs2_o,
  input  logic                     be_done_i,
  output logic                     be_done_ready_o,
  input  logic [XLEN-1:0]          be_result_i,
  output logic                     acc_resp_valid_o,
  input  logic                     acc_resp_ready_i,
  output logic [TRANS_ID_BITS-1:0] acc_resp_trans_id_o,
  output logic [XLEN-1:0]          acc_resp_result_o,
  output logic                     acc_load_complete_o,
  output logic                     acc_store_complete_o,
  output logic                     acc_store_pending_o,
  output logic                     protocol_err_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [6:0]      OpLoad  = 7'b0000111;
  localparam logic [6:0]      OpStore = 7'b0100111;

  typedef struct packed {
    logic [31:0]              insn;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [TRANS_ID_BITS-1:0] id;
    logic                     is_ld;
    logic                     is_st;
  } req_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic                     is_ld;
    logic                     is_st;
  } tag_t;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [CntW-1:0] cnt_upd(input logic [CntW-1:0] c, input logic inc,
                                              input logic dec);
    if (inc && !dec) return c + CntW'(1);
    if (dec && !inc) return c - CntW'(1);
    return c;
  endfunction

  req_t                     req_mem_q [DEPTH];
  tag_t                     tag_mem_q [DEPTH];
  logic [PtrW-1:0]          req_wr_q, req_rd_q, tag_wr_q, tag_rd_q;
  logic [CntW-1:0]          req_cnt_q, tag_cnt_q, inflight_q, st_cnt_q;
  logic                     init_q, err_q;
  logic                     resp_valid_q, resp_ld_q, resp_st_q;
  logic [TRANS_ID_BITS-1:0] resp_id_q;
  logic [XLEN-1:0]          resp_result_q;

  req_t req_in, req_head;
  tag_t tag_in, tag_head;
  logic req_push, issue, done_hs, resp_hs, tag_empty;

  always_comb begin
    req_in.insn  = acc_insn_i;
    req_in.rs1   = acc_rs1_i;
    req_in.rs2   = acc_rs2_i;
    req_in.id    = acc_trans_id_i;
    req_in.is_ld = (acc_insn_i[6:0] == OpLoad);
    req_in.is_st = (acc_insn_i[6:0] == OpStore);
    req_head     = req_mem_q[req_rd_q];
    tag_in.id    = req_head.id;
    tag_in.is_ld = req_head.is_ld;
    tag_in.is_st = req_head.is_st;
    tag_head     = tag_mem_q[tag_rd_q];
  end

  // init_q keeps ready low while in reset and until the first clock after release.
  assign acc_req_ready_o = init_q && (req_cnt_q != CntMax) && (inflight_q < CntMax);
  assign req_push        = acc_req_valid_i && acc_req_ready_o;
  assign be_valid_o      = (req_cnt_q != '0);
  assign issue           = be_valid_o && be_ready_i;
  assign tag_empty       = (tag_cnt_q == '0);
  // Response register may refill in the same cycle it drains.
  assign be_done_ready_o = !tag_empty && (!resp_valid_q || acc_resp_ready_i);
  assign done_hs         = be_done_i && be_done_ready_o;
  assign resp_hs         = resp_valid_q && acc_resp_ready_i;

  // Storage is not reset, so the issue payload is masked when nothing is queued.
  assign be_insn_o = be_valid_o ? req_head.insn : '0;
  assign be_rs1_o  = be_valid_o ? req_head.rs1  : '0;
  assign be_rs2_o  = be_valid_o ? req_head.rs2  : '0;

  assign acc_resp_valid_o     = resp_valid_q;
  assign acc_resp_trans_id_o  = resp_id_q;
  assign acc_resp_result_o    = resp_result_q;
  assign acc_load_complete_o  = resp_hs && resp_ld_q;
  assign acc_store_complete_o = resp_hs && resp_st_q;
  assign acc_store_pending_o  = (st_cnt_q != '0);
  assign protocol_err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (req_push) req_mem_q[req_wr_q] <= req_in;
    if (issue)    tag_mem_q[tag_wr_q] <= tag_in;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q        <= 1'b0;
      err_q         <= 1'b0;
      req_wr_q      <= '0;
      req_rd_q      <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      req_cnt_q     <= '0;
      tag_cnt_q     <= '0;
      inflight_q    <= '0;
      st_cnt_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_ld_q     <= 1'b0;
      resp_st_q     <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
    end else begin
      init_q     <= 1'b1;
      err_q      <= err_q | (be_done_i & tag_empty);
      req_cnt_q  <= cnt_upd(req_cnt_q, req_push, issue);
      tag_cnt_q  <= cnt_upd(tag_cnt_q, issue, done_hs);
      inflight_q <= cnt_upd(inflight_q, req_push, resp_hs);
      st_cnt_q   <= cnt_upd(st_cnt_q, req_push && req_in.is_st, acc_store_complete_o);
      if (req_push) req_wr_q <= ptr_inc(req_wr_q);
      if (issue) begin
        req_rd_q <= ptr_inc(req_rd_q);
        tag_wr_q <= ptr_inc(tag_wr_q);
      end
      if (done_hs) begin
        tag_rd_q      <= ptr_inc(tag_rd_q);
        resp_valid_q  <= 1'b1;
        resp_id_q     <= tag_head.id;
        resp_result_q <= be_result_i;
        resp_ld_q     <= tag_head.is_ld;
        resp_st_q     <= tag_head.is_st;
      end else if (resp_hs) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

endmodule
